axis_result_regs: RTL and testbench
===================================

# axis_result_regs

AXI4-Lite responder for the result side (s2mm) of the AXI-Stream multiplier. It captures result frames from the multiplier's master AXI-Stream port into a small register file and raises a ready flag. It keeps running word and frame counts. Software reads the results through AXI4-Lite and clears the flag.

## Interface
- `C_DATA_WIDTH`, 32: AXI-Stream and AXI-Lite data width.
- `C_ADDR_WIDTH`, 8: AXI-Lite address width (byte address).
- `C_MAX_WORDS`, 4: result words per frame (register slots).
- `aclk`  in  1  single clock for all logic.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  C_DATA_WIDTH  result word.
- `s_axis_tvalid`  in  1  result word valid.
- `s_axis_tlast`  in  1  last word of frame.
- `s_axis_tready`  out  1  capture ready.
- `s_axi_awaddr`  in  C_ADDR_WIDTH; `s_axi_awvalid`  in  1; `s_axi_awready`  out  1.
- `s_axi_wdata`  in  C_DATA_WIDTH; `s_axi_wstrb`  in  C_DATA_WIDTH/8; `s_axi_wvalid`  in  1; `s_axi_wready`  out  1.
- `s_axi_bresp`  out  2; `s_axi_bvalid`  out  1; `s_axi_bready`  in  1.
- `s_axi_araddr`  in  C_ADDR_WIDTH; `s_axi_arvalid`  in  1; `s_axi_arready`  out  1.
- `s_axi_rdata`  out  C_DATA_WIDTH; `s_axi_rresp`  out  2; `s_axi_rvalid`  out  1; `s_axi_rready`  in  1.

## Operation
- Register map:
  - 0x00 STATUS: bit0 = ready flag. Write 1 to bit0 (wstrb[0]=1) to clear it.
  - 0x04 WORD_CNT: total words accepted.
  - 0x08 FRAME_CNT: total frames completed.
  - 0x0C + 4·i RESULT[i], i = 0..C_MAX_WORDS-1.
- Address decode uses the address bits [C_ADDR_WIDTH-1:2]. Bits [1:0] are ignored.
- Capture side:
  - `s_axis_tready` = ~ready_flag.
  - Each accepted beat writes RESULT[idx], increments idx, and increments WORD_CNT (32-bit, wraps).
  - A frame completes on a beat with tlast=1, or on the beat at idx = C_MAX_WORDS-1 with no tlast. On completion: ready_flag←1, FRAME_CNT+1 (wraps), idx←0.
  - Slots not written in a short frame keep their previous values.
- Write channel:
  - AW and W are accepted independently, in either order or the same cycle, into one-deep holding registers.
  - awready = ~aw_held; wready = ~w_held.
  - When both are held and bvalid=0: perform the write, set bvalid=1, bresp=OKAY (00), release both holds.
  - Writes to any address other than 0x00 are ignored, still with bresp=OKAY.
- Read channel:
  - arready = ~rvalid.
  - On the AR handshake, rdata/rresp are registered and rvalid=1 on the next cycle, held until rready.
  - rresp = OKAY for mapped addresses. Unmapped addresses return rdata=0, rresp=SLVERR (10).
- Simultaneous events:
  - A STATUS clear and a read of 0x00 in the same cycle: the read returns the pre-clear value.
  - A clear and a frame completion cannot coincide, because tready=0 while the flag is set.

## Timing
- Reset (aresetn=0, asynchronous):
  - ready_flag, idx, WORD_CNT, FRAME_CNT, RESULT[*] = 0.
  - bvalid = 0, rvalid = 0, bresp = 00, rresp = 00, rdata = 0.
  - awready = wready = arready = 1; tready = 1.
- Reset mid-frame discards the partial frame. Reset with bvalid or rvalid pending drops the response.
- Read latency: one cycle from the AR handshake to rvalid. A testbench driving rready=1 sees rvalid for exactly one cycle.
- Write response: bvalid rises the cycle after the later of the AW and W handshakes.
- Flag/counter visibility: updated on the clock edge of the completing beat. A read issued on the next cycle sees the new value.
- After a clear, tready rises the cycle after the W-completing edge.

## Structure
- Shared package: register offset constants (STATUS, WORD_CNT, FRAME_CNT, RESULT_BASE) and AXI response codes (OKAY, SLVERR). The same constants serve the mm2s-side register block.
- One natural sub-module, `axil_slave_if`: the AXI-Lite handshake and holding logic. It exposes a one-cycle wr_en/wr_addr/wr_data/wr_strb strobe and an rd_en/rd_addr request with registered read data.
- The top level holds the capture FSM (idx and flag), the counters and the register file.

## Test plan
- One-word frame: beat tdata=5, tlast=1 -> STATUS reads 1, RESULT[0]=5, tready=0; write 1 to 0x00 -> STATUS reads 0, tready=1.
- Four-word frame: beats 8, 16, 24, 32 with tlast on the 4th -> RESULT[0..3] = 8, 16, 24, 32; after both frames WORD_CNT=5, FRAME_CNT=2.
- Overrun: five beats, no tlast -> frame closes at beat 4, 5th beat stalls (tready=0) until clear, then lands in RESULT[0].
- AXI ordering: W one cycle before AW, and AW/W in the same cycle -> each produces exactly one bvalid with bresp=00. rready held low for 3 cycles -> rvalid and rdata stable, arready=0.
- Unmapped read 0x40 -> rdata=0, rresp=10. A write to 0x04 leaves WORD_CNT unchanged.
- Reset asserted mid-frame after 2 beats -> all registers read 0 and the next frame starts at RESULT[0].

Source files
------------

// File: rtl/axis_result_regs_pkg.sv
// Shared register map, AXI response codes and capture state encoding for the
// AXI-Stream multiplier register blocks (s2mm result side and mm2s side).
package axis_result_regs_pkg;

  localparam int unsigned REG_STATUS      = 32'h00;
  localparam int unsigned REG_WORD_CNT    = 32'h04;
  localparam int unsigned REG_FRAME_CNT   = 32'h08;
  localparam int unsigned REG_RESULT_BASE = 32'h0C;

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    CAP_ACCEPT = 1'b0,
    CAP_FULL   = 1'b1
  } cap_state_e;

  // Byte offset to 32-bit word index, matching decode on address bits [..:2].
  function automatic int unsigned reg_word(input int unsigned byte_off);
    return byte_off >> 2;
  endfunction

endpackage

// File: rtl/axis_result_regs_axil_slave_if.sv
// AXI4-Lite slave handshake: one-deep AW/W holding registers, single-beat
// write strobe toward the register file, and a registered read response.
module axil_slave_if
  import axis_result_regs_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic                wr_en_c_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o,
  output logic                rd_en_c_o,
  output logic [ADDR_W-1:0]   rd_addr_c_o,
  input  logic [DATA_W-1:0]   rd_data_i,
  input  logic [1:0]          rd_resp_i
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic              aw_held_q;
  logic              w_held_q;
  logic              bvalid_q;
  logic              rvalid_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              wr_fire_c;
  logic              rd_fire_c;

  // A write commits only once both halves are held and no response is pending.
  assign wr_fire_c = aw_held_q & w_held_q & ~bvalid_q;
  assign rd_fire_c = arvalid_i & ~rvalid_q;

  assign awready_o   = ~aw_held_q;
  assign wready_o    = ~w_held_q;
  assign bvalid_o    = bvalid_q;
  assign bresp_o     = RESP_OKAY;
  assign arready_o   = ~rvalid_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign rresp_o     = rresp_q;
  assign wr_en_c_o   = wr_fire_c;
  assign wr_addr_o   = aw_addr_q;
  assign wr_data_o   = w_data_q;
  assign wr_strb_o   = w_strb_q;
  assign rd_en_c_o   = rd_fire_c;
  assign rd_addr_c_o = araddr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (awvalid_i && !aw_held_q) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= awaddr_i;
      end
      if (wvalid_i && !w_held_q) begin
        w_held_q <= 1'b1;
        w_data_q <= wdata_i;
        w_strb_q <= wstrb_i;
      end
      if (wr_fire_c) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
      end else if (bvalid_q && bready_i) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (rd_fire_c) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_i;
      rresp_q  <= rd_resp_i;
    end else if (rvalid_q && rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_result_regs.sv
// Result-side register block: captures AXI-Stream result frames into a small
// register file, counts words/frames, and exposes them over AXI4-Lite.
module axis_result_regs
  import axis_result_regs_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_ADDR_WIDTH = 8,
  parameter int unsigned C_MAX_WORDS  = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int unsigned STRB_W   = C_DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = (C_MAX_WORDS > 1) ? $clog2(C_MAX_WORDS) : 1;
  localparam int unsigned W_STATUS = reg_word(REG_STATUS);
  localparam int unsigned W_WCNT   = reg_word(REG_WORD_CNT);
  localparam int unsigned W_FCNT   = reg_word(REG_FRAME_CNT);
  localparam int unsigned W_RESULT = reg_word(REG_RESULT_BASE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(C_MAX_WORDS - 1);

  cap_state_e                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]          frame_cnt_q, frame_cnt_d;
  logic [C_DATA_WIDTH-1:0]   result_q [C_MAX_WORDS];
  logic                      beat_c;
  logic                      clear_c;
  logic                      ready_flag_c;

  logic                      wr_en_c;
  logic [C_ADDR_WIDTH-1:0]   wr_addr;
  logic [C_DATA_WIDTH-1:0]   wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic                      rd_en_c;
  logic [C_ADDR_WIDTH-1:0]   rd_addr_c;
  logic [C_DATA_WIDTH-1:0]   rd_data_c;
  logic [1:0]                rd_resp_c;
  logic [CNT_W-1:0]          wr_word_c;
  logic [CNT_W-1:0]          rd_word_c;
  logic                      unused_bits;

  axil_slave_if #(
    .DATA_W (C_DATA_WIDTH),
    .ADDR_W (C_ADDR_WIDTH)
  ) u_axil (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .awaddr_i    (s_axi_awaddr),
    .awvalid_i   (s_axi_awvalid),
    .awready_o   (s_axi_awready),
    .wdata_i     (s_axi_wdata),
    .wstrb_i     (s_axi_wstrb),
    .wvalid_i    (s_axi_wvalid),
    .wready_o    (s_axi_wready),
    .bresp_o     (s_axi_bresp),
    .bvalid_o    (s_axi_bvalid),
    .bready_i    (s_axi_bready),
    .araddr_i    (s_axi_araddr),
    .arvalid_i   (s_axi_arvalid),
    .arready_o   (s_axi_arready),
    .rdata_o     (s_axi_rdata),
    .rresp_o     (s_axi_rresp),
    .rvalid_o    (s_axi_rvalid),
    .rready_i    (s_axi_rready),
    .wr_en_c_o   (wr_en_c),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .wr_strb_o   (wr_strb),
    .rd_en_c_o   (rd_en_c),
    .rd_addr_c_o (rd_addr_c),
    .rd_data_i   (rd_data_c),
    .rd_resp_i   (rd_resp_c)
  );

  assign wr_word_c     = CNT_W'(wr_addr[C_ADDR_WIDTH-1:2]);
  assign rd_word_c     = CNT_W'(rd_addr_c[C_ADDR_WIDTH-1:2]);
  assign ready_flag_c  = (state_q == CAP_FULL);
  assign s_axis_tready = ~ready_flag_c;
  assign clear_c       = wr_en_c && (wr_word_c == W_STATUS) && wr_strb[0] && wr_data[0];
  // Byte-lane bits and upper write data carry no meaning in this map.
  assign unused_bits   = ^{wr_data, wr_strb, wr_addr[1:0], rd_addr_c[1:0]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= CAP_ACCEPT;
      idx_q       <= '0;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Capture FSM: a frame closes on tlast or when the last slot is filled.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    beat_c      = 1'b0;
    case (state_q)
      CAP_ACCEPT: begin
        if (s_axis_tvalid) begin
          beat_c     = 1'b1;
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (s_axis_tlast || (idx_q == IDX_LAST)) begin
            state_d     = CAP_FULL;
            idx_d       = '0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      CAP_FULL: begin
        if (clear_c) state_d = CAP_ACCEPT;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < C_MAX_WORDS; i++) result_q[i] <= '0;
    end else if (beat_c) begin
      result_q[idx_q] <= s_axis_tdata;
    end
  end

  // Read decode samples current register values, so a same-cycle clear reads pre-clear.
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    if (rd_en_c) begin
      if (rd_word_c == W_STATUS) begin
        rd_data_c = C_DATA_WIDTH'(ready_flag_c);
      end else if (rd_word_c == W_WCNT) begin
        rd_data_c = C_DATA_WIDTH'(word_cnt_q);
      end else if (rd_word_c == W_FCNT) begin
        rd_data_c = C_DATA_WIDTH'(frame_cnt_q);
      end else begin
        rd_resp_c = RESP_SLVERR;
        for (int unsigned i = 0; i < C_MAX_WORDS; i++) begin
          if (rd_word_c == W_RESULT + i) begin
            rd_data_c = result_q[i];
            rd_resp_c = RESP_OKAY;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_result_regs.sv
// Bench for axis_result_regs: directed scenarios plus randomized traffic,
// checked against a frame-level model of the result register block.
module tb_axis_result_regs;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [7:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  int total = 0;
  int bad = 0;

  // Model: flag, fill position, counters and the four result slots.
  logic        m_flag;
  logic [1:0]  m_pos;
  logic [31:0] m_wcnt;
  logic [31:0] m_fcnt;
  logic [31:0] m_res [4];

  axis_result_regs dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear_all();
    m_flag = 1'b0;
    m_pos  = 2'd0;
    m_wcnt = 32'd0;
    m_fcnt = 32'd0;
    for (int i = 0; i < 4; i++) m_res[i] = 32'd0;
  endtask

  // A beat lands whenever the flag is clear; slot 3 or tlast closes the frame.
  task automatic model_step();
    if (aresetn && s_axis_tvalid && !m_flag) begin
      m_res[m_pos] = s_axis_tdata;
      m_wcnt = m_wcnt + 32'd1;
      if (s_axis_tlast || m_pos == 2'd3) begin
        m_flag = 1'b1;
        m_fcnt = m_fcnt + 32'd1;
        m_pos  = 2'd0;
      end else begin
        m_pos = m_pos + 2'd1;
      end
    end
  endtask

  function automatic void model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int unsigned w;
    w = 32'(a) >> 2;
    d = 32'd0;
    r = 2'b00;
    if (w == 0)      d = 32'(m_flag);
    else if (w == 1) d = m_wcnt;
    else if (w == 2) d = m_fcnt;
    else begin
      r = 2'b10;
      for (int unsigned i = 0; i < 4; i++) begin
        if (w == 3 + i) begin
          d = m_res[i];
          r = 2'b00;
        end
      end
    end
  endfunction

  // One clock: per-cycle tready check on the falling edge, model update on the rising edge.
  task automatic cycle();
    @(negedge aclk);
    if (aresetn) chk("tready", 32'(s_axis_tready), 32'(!m_flag));
    @(posedge aclk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 32'd0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = 8'd0; s_axi_wdata = 32'd0; s_axi_wstrb = 4'd0; s_axi_araddr = 8'd0;
    model_clear_all();
    #1;
    chk("rst_tready", 32'(s_axis_tready), 32'd1);
    chk("rst_awready", 32'(s_axi_awready), 32'd1);
    chk("rst_wready", 32'(s_axi_wready), 32'd1);
    chk("rst_arready", 32'(s_axi_arready), 32'd1);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
    chk("rst_rresp", 32'(s_axi_rresp), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    cycle();
    cycle();
    aresetn = 1'b1;
    cycle();
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last);
    bit acc;
    acc = 1'b0;
    s_axis_tdata = data; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    for (int k = 0; k < 8 && !acc; k++) begin
      acc = s_axis_tready;
      cycle();
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("beat_accept", 32'(acc), 32'd1);
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly);
    bit aw_done, w_done, b_done, aw_hs, w_hs;
    aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_bready = 1'b0;
    for (int k = 0; k < 20 && !b_done; k++) begin
      s_axi_awvalid = !aw_done && (k >= aw_dly);
      s_axi_wvalid  = !w_done && (k >= w_dly);
      if (s_axi_bvalid) begin
        chk("bresp", 32'(s_axi_bresp), 32'd0);
        chk("b_after_aw_w", 32'(aw_done && w_done), 32'd1);
        if (addr[7:2] == 6'd0 && strb[0] && data[0]) m_flag = 1'b0;
        s_axi_bready = 1'b1;
        b_done = 1'b1;
      end
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      cycle();
      if (aw_hs) aw_done = 1'b1;
      if (w_hs) w_done = 1'b1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    chk("b_seen", 32'(b_done), 32'd1);
    chk("b_single", 32'(s_axi_bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [7:0] addr, input int hold,
                          output logic [31:0] d, output logic [1:0] r);
    logic [31:0] ed;
    logic [1:0]  er;
    bit hs, got;
    got = 1'b0; ed = 32'd0; er = 2'b00;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      hs = s_axi_arready;
      if (hs) model_read(addr, ed, er);
      cycle();
      if (hs) got = 1'b1;
    end
    s_axi_arvalid = 1'b0;
    chk("ar_seen", 32'(got), 32'd1);
    chk("rvalid_latency", 32'(s_axi_rvalid), 32'd1);
    for (int k = 0; k < hold; k++) begin
      chk("arready_busy", 32'(s_axi_arready), 32'd0);
      cycle();
      chk("rvalid_hold", 32'(s_axi_rvalid), 32'd1);
      chk("rdata_hold", s_axi_rdata, ed);
    end
    d = s_axi_rdata;
    r = s_axi_rresp;
    chk("rdata", s_axi_rdata, ed);
    chk("rresp", 32'(s_axi_rresp), 32'(er));
    s_axi_rready = 1'b1;
    cycle();
    chk("rvalid_once", 32'(s_axi_rvalid), 32'd0);
    s_axi_rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    #2;
    do_reset();

    // One-word frame, then clear.
    send_beat(32'd5, 1'b1);
    axi_read(8'h00, 0, d, r);  chk("one_status", d, 32'd1);
    axi_read(8'h0C, 0, d, r);  chk("one_res0", d, 32'd5);
    chk("one_tready", 32'(s_axis_tready), 32'd0);
    axi_write(8'h00, 32'd1, 4'h1, 0, 0);
    axi_read(8'h00, 0, d, r);  chk("clr_status", d, 32'd0);
    chk("clr_tready", 32'(s_axis_tready), 32'd1);

    // Four-word frame; a clear without byte-lane 0 must not take effect.
    send_beat(32'd8, 1'b0);
    send_beat(32'd16, 1'b0);
    send_beat(32'd24, 1'b0);
    send_beat(32'd32, 1'b1);
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(12 + 4 * i), 0, d, r);
      chk("four_res", d, 32'(8 * (i + 1)));
    end
    axi_read(8'h04, 0, d, r);  chk("four_wcnt", d, 32'd5);
    axi_read(8'h08, 0, d, r);  chk("four_fcnt", d, 32'd2);
    axi_write(8'h00, 32'd1, 4'h2, 0, 0);
    axi_read(8'h00, 0, d, r);  chk("nostrb_status", d, 32'd1);
    axi_write(8'h00, 32'd1, 4'h1, 2, 0);

    // Overrun: four beats close the frame, the fifth stalls until cleared.
    for (int i = 0; i < 4; i++) send_beat(32'(100 + i), 1'b0);
    axi_read(8'h08, 0, d, r);  chk("ovr_fcnt", d, 32'd3);
    s_axis_tdata = 32'd104; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    repeat (3) cycle();
    chk("ovr_stall", 32'(s_axis_tready), 32'd0);
    axi_write(8'h00, 32'd1, 4'h1, 1, 0);
    s_axis_tvalid = 1'b0;
    axi_read(8'h0C, 0, d, r);  chk("ovr_res0", d, 32'd104);
    axi_read(8'h10, 0, d, r);  chk("ovr_res1_kept", d, 32'd101);
    axi_read(8'h04, 0, d, r);  chk("ovr_wcnt", d, 32'd10);
    axi_read(8'h00, 0, d, r);  chk("ovr_status", d, 32'd0);

    // Writes elsewhere are ignored but still answered OKAY.
    axi_write(8'h04, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_read(8'h04, 0, d, r);  chk("ro_wcnt", d, 32'd10);
    axi_write(8'h08, 32'h0000_0000, 4'hF, 0, 3);

    // Slow master, low address bits ignored, map edges.
    axi_read(8'h0D, 3, d, r);  chk("slow_res0", d, 32'd104);
    axi_read(8'h18, 0, d, r);  chk("last_slot", d, 32'd103); chk("last_slot_resp", 32'(r), 32'd0);
    axi_read(8'h1C, 0, d, r);  chk("past_end", d, 32'd0);    chk("past_end_resp", 32'(r), 32'd2);
    axi_read(8'h40, 0, d, r);  chk("unmapped", d, 32'd0);    chk("unmapped_resp", 32'(r), 32'd2);

    // Reset in the middle of a frame.
    send_beat(32'd7, 1'b0);
    send_beat(32'd9, 1'b0);
    do_reset();
    for (int a = 0; a < 7; a++) begin
      axi_read(8'(4 * a), 0, d, r);
      chk("rst_reg", d, 32'd0);
    end
    send_beat(32'd77, 1'b1);
    axi_read(8'h0C, 0, d, r);  chk("rst_restart", d, 32'd77);
    axi_read(8'h10, 0, d, r);  chk("rst_res1", d, 32'd0);
    axi_write(8'h00, 32'd1, 4'h1, 0, 0);

    // Randomized mix of beats, reads, writes and rare resets.
    for (int it = 0; it < 400; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 4) begin
        if (m_flag) axi_write(8'h00, 32'd1, 4'h1, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        else send_beat($urandom, $urandom_range(0, 3) == 0);
      end else if (op < 7) begin
        axi_read(8'($urandom_range(0, 63)), int'($urandom_range(0, 2)), d, r);
      end else if (op < 9) begin
        axi_write(8'($urandom_range(0, 31)), $urandom, 4'($urandom),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end else if ($urandom_range(0, 9) == 0) begin
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
